// File: rtl/mips16_mc_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit MIPS datapath.
// Ports: i_Clk/i_Rst (async low), i_Run, IR fields, i_Zero, memory acks in;
//        memory requests, datapath enables/selects, state, retire count, fault out.
module mips16_mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Run,
    input  logic [2:0]       i_Opcode,
    input  logic [3:0]       i_Funct,
    input  logic             i_Zero,
    input  logic             i_IMemAck,
    input  logic             i_DMemAck,
    output logic             o_IMemReq,
    output logic             o_DMemReq,
    output logic             o_MemRead,
    output logic             o_MemWrite,
    output logic             o_IRWrite,
    output logic             o_PCWrite,
    output logic [1:0]       o_PCSrc,
    output logic             o_RegWrite,
    output logic [1:0]       o_RegDst,
    output logic [1:0]       o_MemtoReg,
    output logic             o_ALUSrc,
    output logic [2:0]       o_ALUcnt,
    output logic [2:0]       o_State,
    output logic             o_Retire,
    output logic [RET_W-1:0] o_RetCnt,
    output logic             o_Fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_SLTI = 3'd1;
    localparam logic [2:0] OP_J    = 3'd2;
    localparam logic [2:0] OP_JAL  = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_ADDI = 3'd7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [RET_W-1:0]  RET_ONE  = RET_W'(1);

    logic [2:0]        state_q, state_d;
    logic [2:0]        opcode_q, opcode_d;
    // Only legal functs (0..4) are ever executed, so bit 3 need not be kept.
    logic [2:0]        funct_q, funct_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [RET_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic              retire;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            funct_q   <= '0;
            wait_q    <= '0;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            wait_q    <= wait_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    // Next state. The wait counter only survives while a request stays
    // unacknowledged; every other path zeroes it, so entry to FETCH/MEM
    // always starts from 0.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        wait_d   = '0;
        retire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (i_IMemAck)              state_d = S_DECODE;
                else if (wait_q == WAIT_MAX) state_d = S_FAULT;
                else                         wait_d  = wait_q + WAIT_ONE;
            end
            S_DECODE: begin
                opcode_d = i_Opcode;
                funct_d  = i_Funct[2:0];
                if (i_Opcode == OP_J || i_Opcode == OP_JAL)
                    retire = 1'b1;
                else if (i_Opcode == OP_R && i_Funct > 4'd4)
                    state_d = S_FAULT;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (opcode_q == OP_BEQ)
                    retire = 1'b1;
                else if (opcode_q == OP_LW || opcode_q == OP_SW)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (i_DMemAck) begin
                    if (opcode_q == OP_SW) retire  = 1'b1;
                    else                   state_d = S_WB;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_WB:    retire  = 1'b1;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
        if (retire) state_d = i_Run ? S_FETCH : S_IDLE;
        ret_cnt_d = retire ? ret_cnt_q + RET_ONE : ret_cnt_q;
    end

    // Outputs. DECODE looks at the live IR because the latch only
    // takes effect at the end of that cycle.
    always_comb begin
        o_IMemReq  = 1'b0;
        o_DMemReq  = 1'b0;
        o_MemRead  = 1'b0;
        o_MemWrite = 1'b0;
        o_IRWrite  = 1'b0;
        o_PCWrite  = 1'b0;
        o_PCSrc    = 2'd0;
        o_RegWrite = 1'b0;
        o_RegDst   = 2'd0;
        o_MemtoReg = 2'd0;
        o_ALUSrc   = 1'b0;
        o_ALUcnt   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                o_IMemReq = 1'b1;
                if (i_IMemAck) begin
                    o_IRWrite = 1'b1;
                    o_PCWrite = 1'b1;
                end
            end
            S_DECODE: begin
                if (i_Opcode == OP_J || i_Opcode == OP_JAL) begin
                    o_PCWrite = 1'b1;
                    o_PCSrc   = 2'd2;
                end
                if (i_Opcode == OP_JAL) begin
                    o_RegWrite = 1'b1;
                    o_RegDst   = 2'd2;
                    o_MemtoReg = 2'd2;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_R:    o_ALUcnt = funct_q;
                    OP_SLTI: begin
                        o_ALUSrc = 1'b1;
                        o_ALUcnt = ALU_SLT;
                    end
                    OP_BEQ: begin
                        o_ALUcnt  = ALU_SUB;
                        o_PCWrite = i_Zero;
                        o_PCSrc   = 2'd1;
                    end
                    OP_LW, OP_SW, OP_ADDI: o_ALUSrc = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                o_DMemReq  = 1'b1;
                o_MemRead  = (opcode_q == OP_LW);
                o_MemWrite = (opcode_q == OP_SW);
            end
            S_WB: begin
                o_RegWrite = 1'b1;
                o_RegDst   = (opcode_q == OP_R)  ? 2'd1 : 2'd0;
                o_MemtoReg = (opcode_q == OP_LW) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

    assign o_State  = state_q;
    assign o_Retire = retire;
    assign o_RetCnt = ret_cnt_q;
    assign o_Fault  = (state_q == S_FAULT);

endmodule

// File: tb/tb_mips16_mc_ctrl.sv
// Directed bench for mips16_mc_ctrl: per-instruction latency, control
// decode per state, memory wait/timeout, fault and counter wrap.
module tb_mips16_mc_ctrl;

    logic       i_Clk, i_Rst, i_Run, i_Zero, i_IMemAck, i_DMemAck;
    logic [2:0] i_Opcode;
    logic [3:0] i_Funct;
    logic       o_IMemReq, o_DMemReq, o_MemRead, o_MemWrite, o_IRWrite;
    logic       o_PCWrite, o_RegWrite, o_ALUSrc, o_Retire, o_Fault;
    logic [1:0] o_PCSrc, o_RegDst, o_MemtoReg;
    logic [2:0] o_ALUcnt, o_State;
    logic [3:0] o_RetCnt;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] memto_reg;
        logic       alu_src;
        logic [2:0] alu_cnt;
        logic       retire;
        logic       fault;
    } outs_t;

    outs_t outs;
    outs_t snap [8];
    outs_t exp_o;
    int    n_vec = 0;
    int    n_err = 0;
    int    memrd_n;
    int    n;

    assign outs = {o_IMemReq, o_DMemReq, o_MemRead, o_MemWrite, o_IRWrite,
                   o_PCWrite, o_PCSrc, o_RegWrite, o_RegDst, o_MemtoReg,
                   o_ALUSrc, o_ALUcnt, o_Retire, o_Fault};

    mips16_mc_ctrl #(.MEM_TIMEOUT(15), .RET_W(4)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Run(i_Run),
        .i_Opcode(i_Opcode), .i_Funct(i_Funct), .i_Zero(i_Zero),
        .i_IMemAck(i_IMemAck), .i_DMemAck(i_DMemAck),
        .o_IMemReq(o_IMemReq), .o_DMemReq(o_DMemReq),
        .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
        .o_IRWrite(o_IRWrite), .o_PCWrite(o_PCWrite), .o_PCSrc(o_PCSrc),
        .o_RegWrite(o_RegWrite), .o_RegDst(o_RegDst),
        .o_MemtoReg(o_MemtoReg), .o_ALUSrc(o_ALUSrc), .o_ALUcnt(o_ALUcnt),
        .o_State(o_State), .o_Retire(o_Retire), .o_RetCnt(o_RetCnt),
        .o_Fault(o_Fault)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    task automatic cyc();
        @(posedge i_Clk);
        #2;
    endtask

    task automatic rst_seq(input logic run);
        @(posedge i_Clk);
        #2;
        i_Rst = 1'b0;
        i_IMemAck = 1'b0;
        i_DMemAck = 1'b0;
        i_Run = run;
        #2;
        i_Rst = 1'b1;
    endtask

    // Starts in a FETCH cycle; acts as IMEM/DMEM with fixed wait counts and
    // records the outputs seen in each state. Returns cycles to retirement.
    task automatic run_instr(input logic [2:0] op, input logic [3:0] fn,
                             input logic z, input int iw, input int dw,
                             input logic run_after, output int ncyc);
        int  fetch_n = 0;
        int  mem_n = 0;
        logic done = 1'b0;
        ncyc = 0;
        memrd_n = 0;
        i_Opcode = op;
        i_Funct = fn;
        i_Zero = z;
        i_Run = run_after;
        for (int k = 0; k < 40 && !done; k++) begin
            i_IMemAck = (o_State == 3'd1) && (fetch_n == iw);
            i_DMemAck = (o_State == 3'd4) && (mem_n == dw);
            #1;
            snap[o_State] = outs;
            if (o_State == 3'd1) fetch_n++;
            if (o_State == 3'd4) mem_n++;
            if (o_MemRead) memrd_n++;
            ncyc++;
            if (o_Retire) done = 1'b1;
            else cyc();
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL run_timeout op=%0d: no retire seen, retire required", op);
        end
        cyc();
        i_IMemAck = 1'b0;
        i_DMemAck = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (o_State !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", o_State); end
        n_vec++; if (outs !== '0) begin n_err++; $display("FAIL rst_outs got %h want 0", outs); end
        n_vec++; if (o_RetCnt !== 4'd0) begin n_err++; $display("FAIL rst_retcnt got %0d want 0", o_RetCnt); end
        @(posedge i_Clk);
        #2;
        i_Rst = 1'b1;
        i_Run = 1'b1;
        i_Opcode = 3'd4;
        i_Funct = 4'd0;
        i_IMemAck = 1'b1;
        cyc();
        #1;
        n_vec++; if (o_IRWrite !== 1'b1 || o_State !== 3'd1) begin n_err++; $display("FAIL rst_fetch irwrite=%b state=%0d want 1/1", o_IRWrite, o_State); end
        cyc();
        i_IMemAck = 1'b0;
        cyc();
        cyc();
        i_DMemAck = 1'b0;
        #1;
        n_vec++; if (o_MemRead !== 1'b1 || o_State !== 3'd4) begin n_err++; $display("FAIL lw_mem memread=%b state=%0d want 1/4", o_MemRead, o_State); end
        i_Rst = 1'b0;
        #1;
        n_vec++; if (o_State !== 3'd0) begin n_err++; $display("FAIL midrst_state got %0d want 0", o_State); end
        n_vec++; if (outs !== '0) begin n_err++; $display("FAIL midrst_outs got %h want 0", outs); end
        i_Rst = 1'b1;
        cyc();
        n_vec++; if (o_State !== 3'd1) begin n_err++; $display("FAIL post_rst_fetch got %0d want 1", o_State); end
    endtask

    task automatic test_add();
        rst_seq(1'b1);
        cyc();
        run_instr(3'd0, 4'd0, 1'b0, 0, 0, 1'b1, n);
        n_vec++; if (n !== 4) begin n_err++; $display("FAIL add_cycles got %0d want 4", n); end
        n_vec++; if (snap[3].alu_cnt !== 3'd0 || snap[3].alu_src !== 1'b0) begin n_err++; $display("FAIL add_exec alucnt=%0d alusrc=%b want 0/0", snap[3].alu_cnt, snap[3].alu_src); end
        n_vec++; if (snap[5].reg_write !== 1'b1 || snap[5].reg_dst !== 2'd1 || snap[5].memto_reg !== 2'd0) begin n_err++; $display("FAIL add_wb rw=%b dst=%0d m2r=%0d want 1/1/0", snap[5].reg_write, snap[5].reg_dst, snap[5].memto_reg); end
        n_vec++; if (o_RetCnt !== 4'd1 || o_State !== 3'd1) begin n_err++; $display("FAIL add_retire cnt=%0d state=%0d want 1/1", o_RetCnt, o_State); end
    endtask

    task automatic test_lw_wait();
        run_instr(3'd4, 4'd0, 1'b0, 0, 3, 1'b1, n);
        n_vec++; if (n !== 8) begin n_err++; $display("FAIL lw_cycles got %0d want 8", n); end
        n_vec++; if (memrd_n !== 4) begin n_err++; $display("FAIL lw_memread_len got %0d want 4", memrd_n); end
        n_vec++; if (snap[5].memto_reg !== 2'd1 || snap[5].reg_dst !== 2'd0 || snap[5].reg_write !== 1'b1) begin n_err++; $display("FAIL lw_wb m2r=%0d dst=%0d rw=%b want 1/0/1", snap[5].memto_reg, snap[5].reg_dst, snap[5].reg_write); end
        n_vec++; if (o_RetCnt !== 4'd2) begin n_err++; $display("FAIL lw_retcnt got %0d want 2", o_RetCnt); end
    endtask

    task automatic test_alu_ops();
        run_instr(3'd0, 4'd4, 1'b0, 0, 0, 1'b1, n);
        n_vec++; if (snap[3].alu_cnt !== 3'd4) begin n_err++; $display("FAIL slt_alucnt got %0d want 4", snap[3].alu_cnt); end
        run_instr(3'd1, 4'd0, 1'b0, 0, 0, 1'b1, n);
        n_vec++; if (n !== 4 || snap[3].alu_src !== 1'b1 || snap[3].alu_cnt !== 3'd4) begin n_err++; $display("FAIL slti n=%0d alusrc=%b alucnt=%0d want 4/1/4", n, snap[3].alu_src, snap[3].alu_cnt); end
        n_vec++; if (snap[5].reg_dst !== 2'd0 || snap[5].memto_reg !== 2'd0) begin n_err++; $display("FAIL slti_wb dst=%0d m2r=%0d want 0/0", snap[5].reg_dst, snap[5].memto_reg); end
        run_instr(3'd7, 4'd0, 1'b0, 2, 0, 1'b1, n);
        n_vec++; if (n !== 6 || snap[3].alu_src !== 1'b1 || snap[3].alu_cnt !== 3'd0) begin n_err++; $display("FAIL addi n=%0d alusrc=%b alucnt=%0d want 6/1/0", n, snap[3].alu_src, snap[3].alu_cnt); end
        run_instr(3'd5, 4'd0, 1'b0, 0, 0, 1'b1, n);
        n_vec++; if (n !== 4 || snap[4].mem_write !== 1'b1 || snap[4].mem_read !== 1'b0) begin n_err++; $display("FAIL sw n=%0d wr=%b rd=%b want 4/1/0", n, snap[4].mem_write, snap[4].mem_read); end
    endtask

    task automatic test_beq();
        run_instr(3'd6, 4'd0, 1'b1, 0, 0, 1'b1, n);
        n_vec++; if (n !== 3 || snap[3].pc_write !== 1'b1 || snap[3].pc_src !== 2'd1 || snap[3].alu_cnt !== 3'd1) begin n_err++; $display("FAIL beq_taken n=%0d pcw=%b src=%0d alu=%0d want 3/1/1/1", n, snap[3].pc_write, snap[3].pc_src, snap[3].alu_cnt); end
        run_instr(3'd6, 4'd0, 1'b0, 0, 0, 1'b1, n);
        n_vec++; if (n !== 3 || snap[3].pc_write !== 1'b0) begin n_err++; $display("FAIL beq_not_taken n=%0d pcw=%b want 3/0", n, snap[3].pc_write); end
    endtask

    task automatic test_jal_stop();
        run_instr(3'd3, 4'd0, 1'b0, 0, 0, 1'b0, n);
        n_vec++; if (n !== 2) begin n_err++; $display("FAIL jal_cycles got %0d want 2", n); end
        n_vec++; if (snap[2].reg_dst !== 2'd2 || snap[2].memto_reg !== 2'd2 || snap[2].pc_src !== 2'd2 || snap[2].reg_write !== 1'b1 || snap[2].pc_write !== 1'b1) begin n_err++; $display("FAIL jal_decode got %h want dst/m2r/src=2 rw/pcw=1", snap[2]); end
        n_vec++; if (o_State !== 3'd0) begin n_err++; $display("FAIL jal_idle got %0d want 0", o_State); end
        cyc();
        n_vec++; if (o_State !== 3'd0) begin n_err++; $display("FAIL idle_hold got %0d want 0", o_State); end
    endtask

    task automatic test_bad_funct();
        rst_seq(1'b1);
        i_Opcode = 3'd0;
        i_Funct = 4'd9;
        i_IMemAck = 1'b1;
        cyc();
        cyc();
        i_IMemAck = 1'b0;
        cyc();
        #1;
        exp_o = '0;
        exp_o.fault = 1'b1;
        n_vec++; if (o_State !== 3'd7 || outs !== exp_o) begin n_err++; $display("FAIL bad_funct state=%0d outs=%h want 7/%h", o_State, outs, exp_o); end
        cyc();
        n_vec++; if (o_State !== 3'd7) begin n_err++; $display("FAIL fault_sticky got %0d want 7", o_State); end
    endtask

    task automatic test_timeout();
        rst_seq(1'b1);
        cyc();
        repeat (15) cyc();
        #1;
        n_vec++; if (o_State !== 3'd1 || o_IMemReq !== 1'b1) begin n_err++; $display("FAIL to_last_wait state=%0d req=%b want 1/1", o_State, o_IMemReq); end
        cyc();
        n_vec++; if (o_State !== 3'd7 || o_IMemReq !== 1'b0 || o_Fault !== 1'b1) begin n_err++; $display("FAIL to_fault state=%0d req=%b fault=%b want 7/0/1", o_State, o_IMemReq, o_Fault); end
        rst_seq(1'b1);
        i_Opcode = 3'd2;
        cyc();
        repeat (15) cyc();
        i_IMemAck = 1'b1;
        cyc();
        i_IMemAck = 1'b0;
        n_vec++; if (o_State !== 3'd2) begin n_err++; $display("FAIL to_boundary_ack state=%0d want 2", o_State); end
    endtask

    task automatic test_wrap();
        rst_seq(1'b1);
        cyc();
        for (int i = 0; i < 15; i++) run_instr(3'd2, 4'd0, 1'b0, 0, 0, 1'b1, n);
        n_vec++; if (o_RetCnt !== 4'd15) begin n_err++; $display("FAIL wrap_15 got %0d want 15", o_RetCnt); end
        run_instr(3'd2, 4'd0, 1'b0, 0, 0, 1'b1, n);
        n_vec++; if (o_RetCnt !== 4'd0 || n !== 2) begin n_err++; $display("FAIL wrap_0 cnt=%0d n=%0d want 0/2", o_RetCnt, n); end
    endtask

    initial begin
        i_Rst = 1'b0;
        i_Run = 1'b0;
        i_Zero = 1'b0;
        i_IMemAck = 1'b0;
        i_DMemAck = 1'b0;
        i_Opcode = 3'd0;
        i_Funct = 4'd0;
        test_reset();
        test_add();
        test_lw_wait();
        test_alu_ops();
        test_beq();
        test_jal_stop();
        test_bad_funct();
        test_timeout();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips16_mc_ctrl.md
Name: mips16_mc_ctrl

Overview:
- Multicycle sequencer for the 16-bit MIPS datapath. It replaces the single-cycle control decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It handshakes with instruction and data memories that may insert wait states, and it counts retired instructions.
- It sits between the IR/ALU flags and the PC, Regfile, ALU and DMEM enables.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for any memory ack before fault.
- RET_W, 16, width of retired-instruction counter.

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  asynchronous reset, active-low.
- i_Run  in  1  1 = execute; sampled in IDLE and at each retirement.
- i_Opcode  in  3  IR[15:13].
- i_Funct  in  4  IR[3:0].
- i_Zero  in  1  ALU zero flag (BEQ compare).
- i_IMemAck  in  1  IMEM data valid.
- i_DMemAck  in  1  DMEM read data valid / write done.
- o_IMemReq  out  1  instruction fetch request.
- o_DMemReq  out  1  data memory request.
- o_MemRead  out  1  DMEM read.
- o_MemWrite  out  1  DMEM write.
- o_IRWrite  out  1  load IR.
- o_PCWrite  out  1  load PC.
- o_PCSrc  out  2  0 PC+1, 1 branch target, 2 jump target.
- o_RegWrite  out  1  Regfile write enable.
- o_RegDst  out  2  0 Rt, 1 Rd, 2 R7.
- o_MemtoReg  out  2  0 ALU, 1 DMEM, 2 PC+1.
- o_ALUSrc  out  1  0 register, 1 immediate.
- o_ALUcnt  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- o_State  out  3  current state encoding.
- o_Retire  out  1  1-cycle pulse per completed instruction.
- o_RetCnt  out  RET_W  retired count.
- o_Fault  out  1  sticky fault flag.

Behaviour:
- Opcode map: 000 R-type, 001 SLTI, 010 J, 011 JAL, 100 LW, 101 SW, 110 BEQ, 111 ADDI.
- Valid R-type funct values are 0..4, mapping directly to o_ALUcnt. Any other funct is illegal.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. State is registered. Outputs decode combinationally from state, the latched opcode/funct, and the current ack.
- Reset (async, i_Rst=0): state IDLE, o_RetCnt=0, o_Fault=0, wait counter 0, latched opcode/funct 0. All enables and requests are 0; o_PCSrc, o_RegDst, o_MemtoReg and o_ALUcnt are 0.
- Reset mid-instruction aborts immediately. No partial write persists beyond the current cycle.
- IDLE: i_Run=1 -> FETCH.
- FETCH: o_IMemReq=1 until ack. On the i_IMemAck cycle: o_IRWrite=1, o_PCWrite=1, o_PCSrc=0, then -> DECODE.
- DECODE: latch i_Opcode and i_Funct.
  - J: o_PCWrite=1, o_PCSrc=2, retire.
  - JAL: same as J, plus o_RegWrite=1, o_RegDst=2, o_MemtoReg=2 (R7 <= PC+1), retire.
  - R-type with illegal funct: -> FAULT.
  - Otherwise -> EXEC.
- EXEC:
  - R-type: o_ALUSrc=0, o_ALUcnt=funct, -> WB.
  - ADDI, LW, SW: o_ALUSrc=1, ADD. ADDI -> WB; LW/SW -> MEM.
  - SLTI: o_ALUSrc=1, SLT, -> WB.
  - BEQ: o_ALUSrc=0, SUB, o_PCWrite=i_Zero, o_PCSrc=1, retire.
- MEM: o_DMemReq=1; o_MemRead=1 for LW, o_MemWrite=1 for SW. Requests are held stable until ack. On ack: SW retires, LW -> WB.
- WB: o_RegWrite=1.
  - R-type: o_RegDst=1, o_MemtoReg=0.
  - ADDI, SLTI: o_RegDst=0, o_MemtoReg=0.
  - LW: o_RegDst=0, o_MemtoReg=1.
  - Then retire.
- Retire (same cycle as the final action): o_Retire=1, o_RetCnt increments with wrap at 2^RET_W. Next state is FETCH if i_Run=1, else IDLE. i_Run is ignored at other times.
- Wait counter: cleared on entering FETCH or MEM, increments each cycle without ack. An ack arriving in the cycle the counter equals MEM_TIMEOUT is still accepted. Without an ack, on the cycle the counter equals MEM_TIMEOUT: -> FAULT, request dropped next cycle.
- FAULT: o_Fault=1, all enables and requests 0. Only reset exits.
- Acks outside FETCH/MEM are ignored. Ack on the first request cycle gives zero wait states.
- Latency with zero-wait memories (cycles per instruction):
  - J, JAL: 2.
  - BEQ: 3.
  - R-type, ADDI, SLTI, SW: 4.
  - LW: 5.

Test Plan:
- Reset low during MEM of LW -> state 0 and all outputs 0 immediately. After release with i_Run=1, FETCH is entered on the next clock.
- ADD (opcode 000, funct 0), acks same-cycle -> o_Retire after exactly 4 cycles. WB shows o_RegWrite=1, o_RegDst=1, o_ALUcnt was 0 in EXEC. o_RetCnt=1.
- LW with i_DMemAck delayed 3 cycles -> o_MemRead held 4 cycles, then WB with o_MemtoReg=1, 8 total cycles incl. FETCH/DECODE/EXEC.
- BEQ, i_Zero=1 -> o_PCWrite=1 with o_PCSrc=1 in EXEC. BEQ, i_Zero=0 -> no PCWrite in EXEC. Both retire in 3 cycles.
- JAL -> 2 cycles, with DECODE showing o_RegDst=2, o_MemtoReg=2, o_PCSrc=2. i_Run=0 at retire -> IDLE.
- Funct 9 R-type -> FAULT (o_State=7, o_Fault=1). IMEM ack withheld 16 cycles -> FAULT. RET_W=4 with 16 retirements -> o_RetCnt wraps to 0.
